matrix_feeder: RTL and testbench

- Upstream operand stage for `tpuModule`.
- Accepts one A/B operand pair as a serial element stream and stores it in a two-bank operand buffer.
- When the array raises `writeEnable`, it drives one stored pair onto `topInputRow`/`leftInputColumn` over `matrixSize` beats: column k of A and row k of B on beat k.
- Double buffering lets the next pair load while the current one feeds. The block also generates the array's `start`.

---
 rtl/matrix_feeder.sv | 158 +++++++++++++++
 tb/tb_matrix_feeder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_feeder.sv
// Operand feeder for tpuModule: double-buffered A/B pair storage, column/row beat feed and start.
// Optional macro FEEDER_SKEW_EN: diagonal-skewed 2N-1 beat feed instead of the plain N-beat feed.
module matrix_feeder #(
  parameter int unsigned dataSize   = 16,
  parameter int unsigned matrixSize = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   inValid,
  output logic                                   inReady,
  input  logic signed [dataSize-1:0]             inData,
  input  logic                                   writeEnable,
  output logic                                   tpuStart,
  output logic        [matrixSize-1:0][dataSize-1:0] topInputRow,
  output logic        [matrixSize-1:0][dataSize-1:0] leftInputColumn,
  output logic                                   feedActive,
  output logic        [1:0]                      bankFull
);

  localparam int unsigned Elems = matrixSize * matrixSize;
  localparam int unsigned Depth = 2 * Elems;
  localparam int unsigned AddrW = $clog2(Depth);
`ifdef FEEDER_SKEW_EN
  localparam int unsigned NumBeats = 2 * matrixSize - 1;
`else
  localparam int unsigned NumBeats = matrixSize;
`endif
  localparam int unsigned BeatW = $clog2(NumBeats + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFeed = 1'b1;

  typedef logic [matrixSize-1:0][dataSize-1:0] lanes_t;

  // Each bank holds A row-major at 0..N^2-1, then B row-major at N^2..2N^2-1.
  logic [dataSize-1:0] mem_q [2][Depth];

  logic [AddrW-1:0] wc_q, wc_d;
  logic             load_bank_q, load_bank_d;
  logic             feed_bank_q, feed_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic [0:0]       state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [BeatW-1:0] next_beat;
  logic             tpu_start_q, tpu_start_d;
  logic             feed_active_q, feed_active_d;
  lanes_t           top_q, top_d, left_q, left_d;
  lanes_t           top_beat, left_beat;

  logic load_fire, load_last, last_beat, feed_go, feed_done;

  assign inReady   = !bank_full_q[load_bank_q];
  assign load_fire = inValid && inReady;
  assign load_last = load_fire && (wc_q == AddrW'(Depth - 1));
  assign last_beat = (beat_q == BeatW'(NumBeats - 1));
  assign feed_go   = (state_q == StIdle) && writeEnable && bank_full_q[feed_bank_q];
  assign feed_done = (state_q == StFeed) && last_beat;
  assign next_beat = (state_q == StIdle) ? '0 : beat_q + 1'b1;

  // Lane values for the beat that the coming edge will present.
  always_comb begin
    top_beat  = '0;
    left_beat = '0;
    for (int j = 0; j < int'(matrixSize); j++) begin
`ifdef FEEDER_SKEW_EN
      if ((int'(next_beat) >= j) && (int'(next_beat) - j < int'(matrixSize))) begin
        left_beat[j] = mem_q[feed_bank_q][AddrW'(j * int'(matrixSize) + int'(next_beat) - j)];
        top_beat[j]  = mem_q[feed_bank_q][AddrW'(int'(Elems)
                       + (int'(next_beat) - j) * int'(matrixSize) + j)];
      end
`else
      left_beat[j] = mem_q[feed_bank_q][AddrW'(j * int'(matrixSize) + int'(next_beat))];
      top_beat[j]  = mem_q[feed_bank_q][AddrW'(int'(Elems)
                     + int'(next_beat) * int'(matrixSize) + j)];
`endif
    end
  end

  always_comb begin
    wc_d          = wc_q;
    load_bank_d   = load_bank_q;
    feed_bank_d   = feed_bank_q;
    bank_full_d   = bank_full_q;
    state_d       = state_q;
    beat_d        = beat_q;
    feed_active_d = feed_active_q;
    top_d         = top_q;
    left_d        = left_q;
    tpu_start_d   = tpu_start_q | load_last;

    if (load_fire) begin
      if (load_last) begin
        wc_d                     = '0;
        load_bank_d              = ~load_bank_q;
        bank_full_d[load_bank_q] = 1'b1;
      end else begin
        wc_d = wc_q + 1'b1;
      end
    end

    // A load can only complete into an empty bank and a feed only releases a full one,
    // so the set and clear below never collide.
    if (feed_done) begin
      state_d                  = StIdle;
      beat_d                   = '0;
      feed_active_d            = 1'b0;
      top_d                    = '0;
      left_d                   = '0;
      bank_full_d[feed_bank_q] = 1'b0;
      feed_bank_d              = ~feed_bank_q;
    end else if (feed_go || (state_q == StFeed)) begin
      state_d       = StFeed;
      beat_d        = next_beat;
      feed_active_d = 1'b1;
      top_d         = top_beat;
      left_d        = left_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_q[load_bank_q][wc_q] <= inData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_q          <= '0;
      load_bank_q   <= 1'b0;
      feed_bank_q   <= 1'b0;
      bank_full_q   <= 2'b00;
      state_q       <= StIdle;
      beat_q        <= '0;
      tpu_start_q   <= 1'b0;
      feed_active_q <= 1'b0;
      top_q         <= '0;
      left_q        <= '0;
    end else begin
      wc_q          <= wc_d;
      load_bank_q   <= load_bank_d;
      feed_bank_q   <= feed_bank_d;
      bank_full_q   <= bank_full_d;
      state_q       <= state_d;
      beat_q        <= beat_d;
      tpu_start_q   <= tpu_start_d;
      feed_active_q <= feed_active_d;
      top_q         <= top_d;
      left_q        <= left_d;
    end
  end

  assign tpuStart        = tpu_start_q;
  assign feedActive      = feed_active_q;
  assign bankFull        = bank_full_q;
  assign topInputRow     = top_q;
  assign leftInputColumn = left_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed self-checking bench for matrix_feeder; follows FEEDER_SKEW_EN when defined.
module tb_matrix_feeder;

  localparam int N  = 4;
  localparam int DW = 16;
`ifdef FEEDER_SKEW_EN
  localparam int Beats = 2 * N - 1;
`else
  localparam int Beats = N;
`endif

  typedef logic [N-1:0][DW-1:0] lanes_t;

  logic                 clk;
  logic                 reset;
  logic                 inValid;
  logic                 inReady;
  logic signed [DW-1:0] inData;
  logic                 writeEnable;
  logic                 tpuStart;
  lanes_t               topInputRow;
  lanes_t               leftInputColumn;
  logic                 feedActive;
  logic [1:0]           bankFull;

  int checks;
  int failures;

  logic signed [DW-1:0] pa [3][N*N];
  logic signed [DW-1:0] pb [3][N*N];
  lanes_t et, el;

  matrix_feeder #(.dataSize(DW), .matrixSize(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .inValid        (inValid),
    .inReady        (inReady),
    .inData         (inData),
    .writeEnable    (writeEnable),
    .tpuStart       (tpuStart),
    .topInputRow    (topInputRow),
    .leftInputColumn(leftInputColumn),
    .feedActive     (feedActive),
    .bankFull       (bankFull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic lanes_t pack4(input int a0, input int a1, input int a2, input int a3);
    lanes_t r;
    r[0] = 16'(a0);
    r[1] = 16'(a1);
    r[2] = 16'(a2);
    r[3] = 16'(a3);
    return r;
  endfunction

  // Reference lanes for pair p at beat k, straight from the A/B matrices.
  function automatic void model(input int p, input int k, output lanes_t top, output lanes_t left);
    top  = '0;
    left = '0;
    for (int j = 0; j < N; j++) begin
`ifdef FEEDER_SKEW_EN
      if (k - j >= 0 && k - j < N) begin
        left[j] = pa[p][j*N + (k-j)];
        top[j]  = pb[p][(k-j)*N + j];
      end
`else
      left[j] = pa[p][j*N + k];
      top[j]  = pb[p][k*N + j];
`endif
    end
  endfunction

  task automatic push(input logic signed [DW-1:0] v);
    int t;
    inValid = 1'b1;
    inData  = v;
    t = 0;
    while (!inReady && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got inReady=0 for 200 cycles required 1");
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic load_pair(input int p);
    for (int i = 0; i < N*N; i++) push(pa[p][i]);
    for (int i = 0; i < N*N; i++) push(pb[p][i]);
  endtask

  task automatic test_reset;
    reset = 1'b0; inValid = 1'b0; inData = '0; writeEnable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (topInputRow !== '0) begin failures++;
      $display("FAIL reset_top: got %h required 0", topInputRow); end
    checks++; if (leftInputColumn !== '0) begin failures++;
      $display("FAIL reset_left: got %h required 0", leftInputColumn); end
    checks++; if (inReady !== 1'b1) begin failures++;
      $display("FAIL reset_inready: got %b required 1", inReady); end
    checks++; if (tpuStart !== 1'b0) begin failures++;
      $display("FAIL reset_tpustart: got %b required 0", tpuStart); end
    checks++; if (bankFull !== 2'b00) begin failures++;
      $display("FAIL reset_bankfull: got %b required 00", bankFull); end
    checks++; if (feedActive !== 1'b0) begin failures++;
      $display("FAIL reset_feedactive: got %b required 0", feedActive); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (inReady !== 1'b1 || bankFull !== 2'b00) begin failures++;
      $display("FAIL post_reset: got inReady=%b bankFull=%b required 1/00", inReady, bankFull); end
  endtask

  task automatic test_single_pair;
    load_pair(0);
    checks++; if (bankFull !== 2'b01) begin failures++;
      $display("FAIL sp_bankfull: got %b required 01", bankFull); end
    checks++; if (tpuStart !== 1'b1) begin failures++;
      $display("FAIL sp_tpustart: got %b required 1", tpuStart); end
    checks++; if (inReady !== 1'b1) begin failures++;
      $display("FAIL sp_inready: got %b required 1", inReady); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (topInputRow !== '0 || feedActive !== 1'b0 || bankFull !== 2'b01) begin
      failures++;
      $display("FAIL sp_hold: got top=%h active=%b full=%b required 0/0/01",
               topInputRow, feedActive, bankFull); end
    writeEnable = 1'b1;
    for (int k = 0; k < Beats; k++) begin
      @(posedge clk); #1;
      writeEnable = 1'b0;
      model(0, k, et, el);
      checks++; if (topInputRow !== et || leftInputColumn !== el) begin failures++;
        $display("FAIL sp_beat%0d: got top=%h left=%h required top=%h left=%h",
                 k, topInputRow, leftInputColumn, et, el); end
      checks++; if (feedActive !== 1'b1) begin failures++;
        $display("FAIL sp_active%0d: got %b required 1", k, feedActive); end
`ifdef FEEDER_SKEW_EN
      if (k == 1) begin
        checks++;
        if (topInputRow !== pack4(-7, 8, 0, 0) || leftInputColumn !== pack4(2, -1, 0, 0)) begin
          failures++;
          $display("FAIL skew_beat1: got top=%h left=%h", topInputRow, leftInputColumn); end
      end
      if (k == 6) begin
        checks++;
        if (topInputRow !== pack4(0, 0, 0, -14) || leftInputColumn !== pack4(0, 0, 0, -6)) begin
          failures++;
          $display("FAIL skew_beat6: got top=%h left=%h", topInputRow, leftInputColumn); end
      end
`else
      if (k == 0) begin
        checks++;
        if (topInputRow !== pack4(7, 8, 9, 10) || leftInputColumn !== pack4(1, -1, 3, -3)) begin
          failures++;
          $display("FAIL sp_const0: got top=%h left=%h", topInputRow, leftInputColumn); end
      end
      if (k == 3) begin
        checks++;
        if (topInputRow !== pack4(-11, -12, -13, -14)
            || leftInputColumn !== pack4(4, -4, 6, -6)) begin
          failures++;
          $display("FAIL sp_const3: got top=%h left=%h", topInputRow, leftInputColumn); end
      end
`endif
    end
    @(posedge clk); #1;
    checks++; if (topInputRow !== '0 || leftInputColumn !== '0) begin failures++;
      $display("FAIL sp_release_lanes: got top=%h left=%h required 0",
               topInputRow, leftInputColumn); end
    checks++; if (feedActive !== 1'b0 || bankFull !== 2'b00) begin failures++;
      $display("FAIL sp_release_flags: got active=%b full=%b required 0/00",
               feedActive, bankFull); end
  endtask

  task automatic test_back_to_back;
    int t;
    writeEnable = 1'b0;
    load_pair(0);
    load_pair(1);
    checks++; if (bankFull !== 2'b11) begin failures++;
      $display("FAIL b2b_full: got %b required 11", bankFull); end
    checks++; if (inReady !== 1'b0) begin failures++;
      $display("FAIL b2b_stall: got inReady=%b required 0", inReady); end
    inValid = 1'b1;
    inData = pa[2][0];
    writeEnable = 1'b1;
    for (int c = 0; c <= Beats; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        model(0, 0, et, el);
        checks++; if (topInputRow !== et || leftInputColumn !== el) begin failures++;
          $display("FAIL b2b_first_beat0: got top=%h left=%h required top=%h left=%h",
                   topInputRow, leftInputColumn, et, el); end
      end
      if (c < Beats) begin
        checks++; if (inReady !== 1'b0) begin failures++;
          $display("FAIL b2b_ready_e%0d: got %b required 0", c, inReady); end
      end else begin
        checks++; if (inReady !== 1'b1 || feedActive !== 1'b0 || topInputRow !== '0) begin
          failures++;
          $display("FAIL b2b_release: got ready=%b active=%b top=%h required 1/0/0",
                   inReady, feedActive, topInputRow); end
        checks++; if (bankFull !== 2'b01) begin failures++;
          $display("FAIL b2b_release_full: got %b required 01", bankFull); end
      end
    end
    @(posedge clk); #1;
    model(1, 0, et, el);
    checks++; if (feedActive !== 1'b1 || topInputRow !== et || leftInputColumn !== el) begin
      failures++;
      $display("FAIL b2b_second_beat0: got active=%b top=%h left=%h required 1 top=%h left=%h",
               feedActive, topInputRow, leftInputColumn, et, el); end
`ifndef FEEDER_SKEW_EN
    checks++;
    if (topInputRow !== pack4(1, 2, 3, 4) || leftInputColumn !== pack4(3, 3, 3, 3)) begin
      failures++;
      $display("FAIL b2b_second_const: got top=%h left=%h", topInputRow, leftInputColumn); end
`endif
    for (int i = 1; i < N*N; i++) push(pa[2][i]);
    for (int i = 0; i < N*N; i++) push(pb[2][i]);
    t = 0;
    while ((bankFull !== 2'b00 || feedActive !== 1'b0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    writeEnable = 1'b0;
    checks++; if (t >= 200) begin failures++;
      $display("FAIL b2b_drain: got full=%b active=%b required 00/0", bankFull, feedActive); end
  endtask

  task automatic test_reset_mid_feed;
    load_pair(0);
    writeEnable = 1'b1;
    @(posedge clk); #1;
    writeEnable = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++; if (topInputRow !== '0 || leftInputColumn !== '0) begin failures++;
      $display("FAIL rst_lanes: got top=%h left=%h required 0", topInputRow, leftInputColumn); end
    checks++; if (feedActive !== 1'b0 || bankFull !== 2'b00) begin failures++;
      $display("FAIL rst_flags: got active=%b full=%b required 0/00", feedActive, bankFull); end
    checks++; if (tpuStart !== 1'b0 || inReady !== 1'b1) begin failures++;
      $display("FAIL rst_start: got start=%b ready=%b required 0/1", tpuStart, inReady); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) push(pa[2][i]);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    load_pair(1);
    checks++; if (bankFull !== 2'b01 || tpuStart !== 1'b1) begin failures++;
      $display("FAIL rst_reload: got full=%b start=%b required 01/1", bankFull, tpuStart); end
    writeEnable = 1'b1;
    for (int k = 0; k < Beats; k++) begin
      @(posedge clk); #1;
      writeEnable = 1'b0;
      model(1, k, et, el);
      checks++; if (topInputRow !== et || leftInputColumn !== el) begin failures++;
        $display("FAIL rst_beat%0d: got top=%h left=%h required top=%h left=%h",
                 k, topInputRow, leftInputColumn, et, el); end
    end
    @(posedge clk); #1;
    checks++; if (topInputRow !== '0 || feedActive !== 1'b0 || bankFull !== 2'b00) begin
      failures++;
      $display("FAIL rst_release: got top=%h active=%b full=%b required 0/0/00",
               topInputRow, feedActive, bankFull); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pa[0] = '{1, 2, 3, 4, -1, -2, -3, -4, 3, 4, 5, 6, -3, -4, -5, -6};
    pb[0] = '{7, 8, 9, 10, -7, -8, -9, -10, 11, 12, 13, 14, -11, -12, -13, -14};
    pa[1] = '{3, 5, 6, 7, 3, -5, -6, -7, 3, 8, 9, 1, 3, -8, -9, -1};
    pb[1] = '{1, 2, 3, 4, 5, 6, 7, 8, -1, -2, -3, -4, 9, 10, 11, 12};
    for (int i = 0; i < N*N; i++) begin
      pa[2][i] = 16'(20 + i);
      pb[2][i] = 16'(-20 - i);
    end
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_reset_mid_feed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
